// File: rtl/vco_phase_decoder.sv
// Ring-VCO phase decoder: thermometer-coded stage samples -> phase, per-cycle phase
// advance, and a decimated windowed sum delivered over a valid/ready output.
module vco_phase_decoder #(
   parameter int unsigned DEC_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           samp,
   input  logic [31:0]           samp_b,
   input  logic                  en,
   input  logic                  out_ready,
   output logic [6+DEC_LOG2-1:0] out_data,
   output logic                  out_valid,
   output logic                  rail_err,
   output logic                  ovf
);

   localparam int unsigned W = 6 + DEC_LOG2;

   logic [31:0]         s1_samp_q, s1_samp_b_q;
   logic                s1_vld_q;
   logic [5:0]          phase_cur_q, phase_prev_q;
   logic [1:0]          prime_q;
   logic                diff_vld_q;
   logic [W-1:0]        acc_q;
   logic [DEC_LOG2-1:0] cnt_q;

   logic [5:0]   n_ones;
   logic [5:0]   phase_raw;
   logic [5:0]   phase_new;
   logic         rail_ok;
   logic [5:0]   diff;
   logic [W-1:0] sum;
   logic         win_done;

   always_comb begin
      n_ones = '0;
      for (int i = 0; i < 32; i++) begin
         n_ones = n_ones + 6'(s1_samp_q[i]);
      end
   end

   always_comb begin
      phase_raw = '0;
      if (s1_samp_q[0]) begin
         phase_raw = n_ones;
      end else if (n_ones != '0) begin
         phase_raw = 6'(7'd64 - 7'(n_ones));
      end
   end

   // A rail-inconsistent sample holds the last phase, i.e. contributes zero advance.
   assign rail_ok   = (s1_samp_q == ~s1_samp_b_q);
   assign phase_new = rail_ok ? phase_raw : phase_cur_q;
   assign diff      = phase_cur_q - phase_prev_q;
   assign sum       = acc_q + W'(diff);
   assign win_done  = en && diff_vld_q && (cnt_q == '1);

   // S1: raw sample capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_samp_q   <= '0;
         s1_samp_b_q <= '0;
         s1_vld_q    <= 1'b0;
      end else if (!en) begin
         s1_samp_q   <= '0;
         s1_samp_b_q <= '0;
         s1_vld_q    <= 1'b0;
      end else begin
         s1_samp_q   <= samp;
         s1_samp_b_q <= samp_b;
         s1_vld_q    <= 1'b1;
      end
   end

   // S2: phase history; a diff is produced only once two phases have primed the pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_cur_q  <= '0;
         phase_prev_q <= '0;
         prime_q      <= '0;
         diff_vld_q   <= 1'b0;
      end else if (!en) begin
         phase_cur_q  <= '0;
         phase_prev_q <= '0;
         prime_q      <= '0;
         diff_vld_q   <= 1'b0;
      end else if (s1_vld_q) begin
         phase_cur_q  <= phase_new;
         phase_prev_q <= phase_cur_q;
         if (prime_q != 2'd2) begin
            prime_q <= prime_q + 2'd1;
         end
         diff_vld_q   <= (prime_q == 2'd2);
      end else begin
         diff_vld_q   <= 1'b0;
      end
   end

   // Window accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (!en) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (diff_vld_q) begin
         cnt_q <= cnt_q + 1'b1;
         acc_q <= win_done ? '0 : sum;
      end
   end

   // Output register and sticky flags; unaffected by en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         rail_err  <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (en && s1_vld_q && !rail_ok) begin
            rail_err <= 1'b1;
         end
         if (win_done) begin
            if (!out_valid || out_ready) begin
               out_data  <= sum;
               out_valid <= 1'b1;
            end else begin
               ovf <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vco_phase_decoder.sv
// Directed bench for vco_phase_decoder: table of whole-window vectors plus hand-written
// backpressure, back-to-back and reset/enable sequences.
module tb_vco_phase_decoder;

   localparam int unsigned DL = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   samp, samp_b;
   logic          en, out_ready;
   logic [DL+5:0] out_data;
   logic          out_valid, rail_err, ovf;

   int pass_cnt  = 0;
   int total_cnt = 0;

   vco_phase_decoder #(.DEC_LOG2(DL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .samp      (samp),
      .samp_b    (samp_b),
      .en        (en),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .rail_err  (rail_err),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          p0;
      int          stp;
      int          mod_k;
      logic [31:0] sx;
      logic [31:0] sbx;
      int          exp_sum;
      int          exp_rail;
   } win_t;

   win_t tbl[9];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // Canonical pattern: bit i set iff (p-i) mod 64 lies in 1..32
   function automatic logic [31:0] pat(input int p);
      logic [31:0] v;
      int d;
      for (int i = 0; i < 32; i++) begin
         d = ((p - i) % 64 + 64) % 64;
         v[i] = (d >= 1 && d <= 32);
      end
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int p);
      samp   = pat(p);
      samp_b = ~pat(p);
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic run_window(input win_t w, input string name);
      en        = 1'b0;
      out_ready = 1'b1;
      step();
      en = 1'b1;
      for (int k = 0; k < 14; k++) begin
         samp   = pat(w.p0 + k * w.stp);
         samp_b = ~samp;
         if (k == w.mod_k) begin
            samp   = samp ^ w.sx;
            samp_b = samp_b ^ w.sbx;
         end
         step();
         if (k == 10) check({name, " early"}, 32'(out_valid), 32'd0);
         if (k == 11) begin
            check({name, " valid"}, 32'(out_valid), 32'd1);
            check({name, " data"}, 32'(out_data), 32'(w.exp_sum));
            check({name, " rail_err"}, 32'(rail_err), 32'(w.exp_rail));
         end
      end
   endtask

   initial begin
      tbl[0] = '{0, 5, -1, 32'h0, 32'h0, 40, 0};
      tbl[1] = '{60, 2, -1, 32'h0, 32'h0, 16, 0};
      tbl[2] = '{7, 0, -1, 32'h0, 32'h0, 0, 0};
      tbl[3] = '{10, 63, -1, 32'h0, 32'h0, 504, 0};
      tbl[4] = '{0, 32, -1, 32'h0, 32'h0, 256, 0};
      tbl[5] = '{1, 33, -1, 32'h0, 32'h0, 264, 0};
      tbl[6] = '{0, 5, 9, 32'h0010_0000, 32'h0010_0000, 41, 0};
      tbl[7] = '{0, 5, 9, 32'h0, 32'h0000_0080, 35, 1};
      tbl[8] = '{3, 7, -1, 32'h0, 32'h0, 56, 1};

      rst_n     = 1'b0;
      en        = 1'b0;
      out_ready = 1'b0;
      samp      = '0;
      samp_b    = '1;
      step();
      step();
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_data", 32'(out_data), 32'd0);
      check("reset rail_err", 32'(rail_err), 32'd0);
      check("reset ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 9; i++) run_window(tbl[i], $sformatf("win%0d", i));
      check("table ovf", 32'(ovf), 32'd0);

      // Backpressure across two completions
      do_reset();
      en        = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         feed((k <= 9) ? 5 * k : 45 + 3 * (k - 9));
         if (k == 11) begin
            check("bp first valid", 32'(out_valid), 32'd1);
            check("bp first data", 32'(out_data), 32'd40);
         end
         if (k == 18) check("bp ovf before", 32'(ovf), 32'd0);
         if (k == 19) begin
            check("bp held valid", 32'(out_valid), 32'd1);
            check("bp held data", 32'(out_data), 32'd40);
            check("bp ovf", 32'(ovf), 32'd1);
         end
      end
      out_ready = 1'b1;
      feed(45 + 3 * 11);
      check("bp valid falls", 32'(out_valid), 32'd0);
      check("bp ovf sticky", 32'(ovf), 32'd1);

      // Back-to-back replacement on the completion cycle
      do_reset();
      en        = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 21; k++) begin
         if (k == 19) out_ready = 1'b1;
         feed((k <= 9) ? 5 * k : 45 + 2 * (k - 9));
         if (k == 11) check("b2b first data", 32'(out_data), 32'd40);
         if (k == 15) check("b2b pending valid", 32'(out_valid), 32'd1);
         if (k == 19) begin
            check("b2b valid", 32'(out_valid), 32'd1);
            check("b2b data", 32'(out_data), 32'd16);
            check("b2b ovf", 32'(ovf), 32'd0);
         end
         if (k == 20) check("b2b drain", 32'(out_valid), 32'd0);
      end

      // Reset mid-window with a pending result and rail_err set
      do_reset();
      en        = 1'b1;
      out_ready = 1'b0;
      for (int k = 0; k < 17; k++) begin
         samp   = pat(5 * k);
         samp_b = (k == 3) ? ~samp ^ 32'h0000_0080 : ~samp;
         step();
         if (k == 11) begin
            check("mid data pre", 32'(out_data), 32'd40);
            check("mid rail pre", 32'(rail_err), 32'd1);
         end
      end
      rst_n = 1'b0;
      #2;
      check("async out_valid", 32'(out_valid), 32'd0);
      check("async out_data", 32'(out_data), 32'd0);
      check("async rail_err", 32'(rail_err), 32'd0);
      check("async ovf", 32'(ovf), 32'd0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         feed(7 + 3 * k);
         if (k == 10) check("post-reset early", 32'(out_valid), 32'd0);
         if (k == 11) begin
            check("post-reset valid", 32'(out_valid), 32'd1);
            check("post-reset data", 32'(out_data), 32'd24);
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/vco_phase_decoder.md
VCO_PHASE_DECODER -- requirements
Module: vco_phase_decoder

Interface
REQ-001 SHALL have parameter DEC_LOG2, default 3: the decimation window is 2^DEC_LOG2 phase differences.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port samp, input, 32: sampled ring-VCO stage outputs (true rail).
REQ-005 SHALL have port samp_b, input, 32: sampled complement rail.
REQ-006 SHALL have port en, input, 1: decode enable; low clears the pipeline and the window.
REQ-007 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-008 SHALL have port out_data, output, 6+DEC_LOG2: summed phase advance over one window.
REQ-009 SHALL have port out_valid, output, 1: out_data holds an unaccepted result.
REQ-010 SHALL have port rail_err, output, 1: sticky flag; a sample violated samp == ~samp_b.
REQ-011 SHALL have port ovf, output, 1: sticky flag; a window result was dropped.

Function
REQ-012 SHALL register samp and samp_b every cycle while en=1; this is stage S1.
REQ-013 SHALL decode the S1 value into a 6-bit phase p (0..63), where canonical pattern p has bit i = 1 iff (p-i) mod 64 lies in 1..32.
REQ-014 SHALL compute p as follows, with n = popcount of the S1 samp: if bit0=1 then p=n; else if n=0 then p=0; else p=64-n. Non-canonical (bubble) patterns use the same rule.
REQ-015 SHALL, when S1 samp != ~S1 samp_b, reuse the previous phase for that cycle and set rail_err.
REQ-016 SHALL register p into phase_cur on the cycle after S1 (stage S2), with phase_prev <= phase_cur.
REQ-017 SHALL compute diff = (phase_cur - phase_prev) mod 64 as 6-bit unsigned, wrapping: cur=2, prev=62 gives 4.
REQ-018 SHALL treat the first two valid S2 phases after reset or after en rises as priming, producing no diff.
REQ-019 SHALL add each diff to an accumulator of width 6+DEC_LOG2 and increment a window counter of width DEC_LOG2.
REQ-020 SHALL, on the cycle the 2^DEC_LOG2-th diff is accumulated, present the sum (including that diff) as the window result, then restart the accumulator at 0.
REQ-021 SHALL give a latency of 3 clk edges from the samp edge carrying the last diff of a window to out_valid=1.
REQ-022 SHALL load the window result into out_data and set out_valid when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (back-to-back with no bubble).
REQ-023 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL clear out_valid on the cycle after out_valid=1 and out_ready=1 when no new result arrives.
REQ-025 SHALL, when a window result arrives while out_valid=1 and out_ready=0, drop the new result, keep the old one, and set ovf.
REQ-026 SHALL, when en=0, clear S1, the phases, priming, accumulator and window counter within 1 cycle, while leaving out_valid/out_data pending and the sticky flags unchanged.
REQ-027 SHALL ensure the sum never overflows: the maximum sum is 63*2^DEC_LOG2, which is less than 2^(6+DEC_LOG2).

Reset
REQ-028 SHALL, with rst_n=0, asynchronously set out_data=0, out_valid=0, rail_err=0, ovf=0, and clear all pipeline, phase, priming, accumulator and counter state.
REQ-029 SHALL resume at the next rising edge after rst_n deasserts, beginning with priming; reset mid-window discards the partial sum.

Verification
REQ-030 Steady rotation: en=1, DEC_LOG2=3, phase advancing +5 per cycle from p=0 with complementary rails -> first out_data=40, then 40 every 8 cycles, rail_err=0.
REQ-031 Wrap: phase sequence 60, 62, 0, 2, ... (+2 per cycle) -> every diff is 2 and out_data=16; no negative or large diffs.
REQ-032 Rail fault: one sample with samp_b[7] flipped -> rail_err=1 and stays set; that cycle reuses the previous phase, so the window sum drops by the skipped advance.
REQ-033 Backpressure: out_ready=0 across two window completions -> first result held unchanged, second dropped, ovf=1; out_ready=1 -> out_valid falls the next cycle.
REQ-034 Back-to-back: out_ready held at 1 on the completion cycle -> new out_data replaces the old with out_valid continuously 1.
REQ-035 Reset/enable mid-window: rst_n pulsed low after 5 diffs -> all outputs are 0 immediately; the next result needs 2 priming cycles plus 8 diffs; en low/high behaves the same except flags persist.
